// File: rtl/cpu_bus_master.sv
// Byte-stream command decoder that acts as the sole master of the CPU register/SRAM bus.
// Handles single write, burst write and read commands and returns ack, error or read-data bytes.
module cpu_bus_master #(
  parameter int unsigned ADR_W    = 18,
  parameter int unsigned READ_LAT = 2,
  parameter int unsigned TIMEOUT  = 1000000
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [7:0]       RX_DATA,
  input  logic             RX_VALID,
  output logic             RX_READY,
  output logic [7:0]       TX_DATA,
  output logic             TX_VALID,
  input  logic             TX_READY,
  output logic             CPU_WR,
  output logic             CPU_RD,
  output logic [ADR_W-1:0] CPU_ADR,
  output logic [31:0]      CPU_WDATA,
  input  logic [31:0]      CPU_RDATA,
  output logic             BUSY,
  output logic             ERR
);

  localparam int unsigned   TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [3:0]    RD_LAST  = 4'(READ_LAT - 1);
  localparam logic [7:0]    OP_WR    = 8'h57;
  localparam logic [7:0]    OP_BW    = 8'h42;
  localparam logic [7:0]    OP_RD    = 8'h52;
  localparam logic [7:0]    ACK      = 8'h06;
  localparam logic [7:0]    NAK      = 8'hEE;

  typedef enum logic [3:0] {
    IDLE, GET_ADR, GET_CNT, GET_DAT, WR_STB, WR_GAP, RD_WAIT, RD_CAP, SEND, ABORT
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        op_q, op_d;
  logic [23:0]       sh_q, sh_d;
  logic [1:0]        fcnt_q, fcnt_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [3:0]        rdc_q, rdc_d;
  logic [31:0]       txbuf_q, txbuf_d;
  logic [2:0]        nb_q, nb_d;
  logic [ADR_W-1:0]  adr_d;
  logic [31:0]       wdata_d;
  logic              rx_fire, tx_fire, tmo_hit, known_op;

  assign rx_fire  = RX_VALID & RX_READY;
  assign tx_fire  = TX_VALID & TX_READY;
  assign tmo_hit  = (TIMEOUT != 0) && (tmo_q == TMO_LAST);
  assign known_op = (RX_DATA == OP_WR) || (RX_DATA == OP_BW) || (RX_DATA == OP_RD);

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rx_fire) state_d = known_op ? GET_ADR : ABORT;
      GET_ADR: begin
        if (rx_fire) begin
          if (fcnt_q == 2'd2)
            state_d = (op_q == OP_RD) ? RD_WAIT : ((op_q == OP_BW) ? GET_CNT : GET_DAT);
        end else if (tmo_hit) state_d = ABORT;
      end
      GET_CNT: begin
        if (rx_fire) begin
          if (fcnt_q == 2'd1) state_d = ({sh_q[7:0], RX_DATA} == 16'h0) ? SEND : GET_DAT;
        end else if (tmo_hit) state_d = ABORT;
      end
      GET_DAT: begin
        if (rx_fire) begin
          if (fcnt_q == 2'd3) state_d = WR_STB;
        end else if (tmo_hit) state_d = ABORT;
      end
      WR_STB:  state_d = WR_GAP;
      WR_GAP:  state_d = ((op_q == OP_BW) && (wcnt_q != 16'd1)) ? GET_DAT : SEND;
      RD_WAIT: if (rdc_q == RD_LAST) state_d = RD_CAP;
      RD_CAP:  state_d = SEND;
      SEND:    if (tx_fire && (nb_q == 3'd1)) state_d = IDLE;
      ABORT:   state_d = SEND;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and next values of the registered outputs
  always_comb begin
    op_d    = op_q;
    sh_d    = sh_q;
    fcnt_d  = fcnt_q;
    wcnt_d  = wcnt_q;
    tmo_d   = tmo_q;
    rdc_d   = rdc_q;
    txbuf_d = txbuf_q;
    nb_d    = nb_q;
    adr_d   = CPU_ADR;
    wdata_d = CPU_WDATA;
    unique case (state_q)
      IDLE: if (rx_fire) begin
        op_d   = RX_DATA;
        fcnt_d = 2'd0;
        tmo_d  = '0;
      end
      GET_ADR, GET_CNT, GET_DAT: begin
        if (rx_fire) begin
          sh_d   = {sh_q[15:0], RX_DATA};
          fcnt_d = fcnt_q + 2'd1;
          tmo_d  = '0;
          if (state_q == GET_ADR && fcnt_q == 2'd2) begin
            adr_d  = ADR_W'({sh_q[15:0], RX_DATA});
            fcnt_d = 2'd0;
            rdc_d  = 4'd0;
          end
          if (state_q == GET_CNT && fcnt_q == 2'd1) begin
            wcnt_d  = {sh_q[7:0], RX_DATA};
            fcnt_d  = 2'd0;
            txbuf_d = {ACK, 24'h0};
            nb_d    = 3'd1;
          end
          if (state_q == GET_DAT && fcnt_q == 2'd3) wdata_d = {sh_q[23:0], RX_DATA};
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WR_GAP: begin
        if (state_d == GET_DAT) begin
          adr_d  = CPU_ADR + ADR_W'(4);
          wcnt_d = wcnt_q - 16'd1;
          fcnt_d = 2'd0;
          tmo_d  = '0;
        end else begin
          txbuf_d = {ACK, 24'h0};
          nb_d    = 3'd1;
        end
      end
      RD_WAIT: rdc_d = rdc_q + 4'd1;
      RD_CAP: begin
        txbuf_d = CPU_RDATA;
        nb_d    = 3'd4;
      end
      SEND: if (tx_fire) begin
        txbuf_d = {txbuf_q[23:0], 8'h0};
        nb_d    = nb_q - 3'd1;
      end
      ABORT: begin
        txbuf_d = {NAK, 24'h0};
        nb_d    = 3'd1;
      end
      default: ;
    endcase
  end

  // Registered outputs follow the state being entered
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      op_q      <= '0;
      sh_q      <= '0;
      fcnt_q    <= '0;
      wcnt_q    <= '0;
      tmo_q     <= '0;
      rdc_q     <= '0;
      txbuf_q   <= '0;
      nb_q      <= '0;
      RX_READY  <= 1'b0;
      TX_VALID  <= 1'b0;
      TX_DATA   <= '0;
      CPU_WR    <= 1'b0;
      CPU_RD    <= 1'b0;
      CPU_ADR   <= '0;
      CPU_WDATA <= '0;
      BUSY      <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      op_q      <= op_d;
      sh_q      <= sh_d;
      fcnt_q    <= fcnt_d;
      wcnt_q    <= wcnt_d;
      tmo_q     <= tmo_d;
      rdc_q     <= rdc_d;
      txbuf_q   <= txbuf_d;
      nb_q      <= nb_d;
      RX_READY  <= (state_d == IDLE) || (state_d == GET_ADR) ||
                   (state_d == GET_CNT) || (state_d == GET_DAT);
      TX_VALID  <= (state_d == SEND);
      TX_DATA   <= txbuf_d[31:24];
      CPU_WR    <= (state_d == WR_STB);
      CPU_RD    <= (state_d == RD_WAIT);
      CPU_ADR   <= adr_d;
      CPU_WDATA <= wdata_d;
      BUSY      <= (state_d != IDLE);
      ERR       <= (state_d == ABORT);
    end
  end

endmodule

// File: tb/tb_cpu_bus_master.sv
// Directed bench for cpu_bus_master: write, read, burst wrap, bad opcode, timeout,
// TX back-pressure and reset in the middle of a burst.
module tb_cpu_bus_master;

  localparam int unsigned ADR_W = 18;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic [7:0]       RX_DATA = 8'h0;
  logic             RX_VALID = 1'b0;
  logic             RX_READY;
  logic [7:0]       TX_DATA;
  logic             TX_VALID;
  logic             TX_READY = 1'b1;
  logic             CPU_WR;
  logic             CPU_RD;
  logic [ADR_W-1:0] CPU_ADR;
  logic [31:0]      CPU_WDATA;
  logic [31:0]      CPU_RDATA = 32'h0;
  logic             BUSY;
  logic             ERR;

  cpu_bus_master #(.ADR_W(ADR_W), .READ_LAT(2), .TIMEOUT(16)) dut (
    .CLK(CLK), .RESET(RESET), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY), .CPU_WR(CPU_WR),
    .CPU_RD(CPU_RD), .CPU_ADR(CPU_ADR), .CPU_WDATA(CPU_WDATA), .CPU_RDATA(CPU_RDATA),
    .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Decoder model: read data registered one cycle after the address
  logic [31:0] rd_val = 32'h0;
  always @(posedge CLK) CPU_RDATA <= CPU_RD ? rd_val : 32'h0;

  // Bus/link observers, sampled on the falling edge
  logic [7:0]       txq[$];
  logic [ADR_W-1:0] wadr[$];
  logic [31:0]      wdat[$];
  logic [ADR_W-1:0] gadr[$];
  logic             gwr[$];
  int               err_cnt = 0;
  int               rd_cnt = 0;
  int               coll_cnt = 0;
  logic [ADR_W-1:0] rd_last = '0;
  logic             prev_wr = 1'b0;

  always @(negedge CLK) begin
    if (RESET) begin
      prev_wr = 1'b0;
    end else begin
      if (TX_VALID && TX_READY) txq.push_back(TX_DATA);
      if (prev_wr) begin gadr.push_back(CPU_ADR); gwr.push_back(CPU_WR); end
      if (CPU_WR) begin wadr.push_back(CPU_ADR); wdat.push_back(CPU_WDATA); end
      if (CPU_RD) begin rd_cnt++; rd_last = CPU_ADR; end
      if (ERR) err_cnt++;
      if (CPU_WR && (ERR || TX_VALID)) coll_cnt++;
      prev_wr = CPU_WR;
    end
  end

  int total = 0;
  int bad = 0;
  int tx_base, wr_base, err_base, rd_base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    tx_base  = txq.size();
    wr_base  = wadr.size();
    err_base = err_cnt;
    rd_base  = rd_cnt;
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte was taken
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    RX_DATA = b;
    RX_VALID = 1'b1;
    @(negedge CLK);
    while (!RX_READY && n < 100) begin @(negedge CLK); n++; end
    if (n >= 100) chk("rx_accept", 32'(RX_READY), 32'd1);
    @(posedge CLK); #1;
    RX_VALID = 1'b0;
  endtask

  task automatic send_adr(input logic [23:0] a);
    send_byte(a[23:16]); send_byte(a[15:8]); send_byte(a[7:0]);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]); send_byte(w[7:0]);
  endtask

  task automatic wait_tx(input int n);
    int k = 0;
    while (txq.size() < tx_base + n && k < 300) begin @(posedge CLK); #1; k++; end
    repeat (3) @(posedge CLK);
    #1;
    chk("tx_count", 32'(txq.size()), 32'(tx_base + n));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rx_ready"}, 32'(RX_READY), 32'd0);
    chk({tag, "_tx_valid"}, 32'(TX_VALID), 32'd0);
    chk({tag, "_tx_data"},  32'(TX_DATA),  32'd0);
    chk({tag, "_cpu_wr"},   32'(CPU_WR),   32'd0);
    chk({tag, "_cpu_rd"},   32'(CPU_RD),   32'd0);
    chk({tag, "_cpu_adr"},  32'(CPU_ADR),  32'd0);
    chk({tag, "_cpu_wdata"}, CPU_WDATA,    32'd0);
    chk({tag, "_busy"},     32'(BUSY),     32'd0);
    chk({tag, "_err"},      32'(ERR),      32'd0);
  endtask

  initial begin
    int k;
    // Reset state
    idle(3);
    @(negedge CLK);
    chk_all_zero("rst");
    @(posedge CLK); #1;
    RESET = 1'b0;
    idle(2);
    chk("idle_rx_ready", 32'(RX_READY), 32'd1);
    chk("idle_busy", 32'(BUSY), 32'd0);

    // Single write
    snap();
    send_byte(8'h57); send_adr(24'h030000); send_word(32'hDEADBEEF);
    wait_tx(1);
    chk("wr_count", 32'(wadr.size() - wr_base), 32'd1);
    chk("wr_adr", 32'(wadr[wr_base]), 32'h30000);
    chk("wr_data", wdat[wr_base], 32'hDEADBEEF);
    chk("wr_gap_adr", 32'(gadr[wr_base]), 32'h30000);
    chk("wr_gap_wr", 32'(gwr[wr_base]), 32'd0);
    chk("wr_ack", 32'(txq[tx_base]), 32'h06);
    chk("wr_busy_after", 32'(BUSY), 32'd0);

    // Read with two-cycle latency
    snap();
    rd_val = 32'h12345678;
    send_byte(8'h52); send_adr(24'h031008);
    wait_tx(4);
    chk("rd_cycles", 32'(rd_cnt - rd_base), 32'd2);
    chk("rd_adr", 32'(rd_last), 32'h31008);
    chk("rd_b0", 32'(txq[tx_base]),     32'h12);
    chk("rd_b1", 32'(txq[tx_base + 1]), 32'h34);
    chk("rd_b2", 32'(txq[tx_base + 2]), 32'h56);
    chk("rd_b3", 32'(txq[tx_base + 3]), 32'h78);
    chk("rd_no_wr", 32'(wadr.size() - wr_base), 32'd0);
    chk("rd_adr_held", 32'(CPU_ADR), 32'h31008);
    chk("rd_rd_low", 32'(CPU_RD), 32'd0);

    // Burst wrapping past the top of the address space
    snap();
    send_byte(8'h42); send_adr(24'h03FFFC); send_byte(8'h00); send_byte(8'h02);
    send_word(32'h11223344); send_word(32'h55667788);
    wait_tx(1);
    chk("bw_count", 32'(wadr.size() - wr_base), 32'd2);
    chk("bw_adr0", 32'(wadr[wr_base]), 32'h3FFFC);
    chk("bw_adr1", 32'(wadr[wr_base + 1]), 32'h00000);
    chk("bw_dat0", wdat[wr_base], 32'h11223344);
    chk("bw_dat1", wdat[wr_base + 1], 32'h55667788);
    chk("bw_ack", 32'(txq[tx_base]), 32'h06);

    // Zero-length burst
    snap();
    send_byte(8'h42); send_adr(24'h000100); send_byte(8'h00); send_byte(8'h00);
    wait_tx(1);
    chk("bw0_count", 32'(wadr.size() - wr_base), 32'd0);
    chk("bw0_ack", 32'(txq[tx_base]), 32'h06);

    // Unknown opcode, then a normal command
    snap();
    send_byte(8'hA5);
    wait_tx(1);
    chk("bad_op_err", 32'(err_cnt - err_base), 32'd1);
    chk("bad_op_nak", 32'(txq[tx_base]), 32'hEE);
    snap();
    send_byte(8'h57); send_adr(24'h000010); send_word(32'h00000001);
    wait_tx(1);
    chk("after_bad_adr", 32'(wadr[wr_base]), 32'h10);
    chk("after_bad_dat", wdat[wr_base], 32'h1);
    chk("after_bad_ack", 32'(txq[tx_base]), 32'h06);

    // Inter-byte timeout of 16 idle cycles
    snap();
    send_byte(8'h57); send_byte(8'h01);
    k = 0;
    while (!ERR && k < 40) begin @(negedge CLK); k++; end
    chk("tmo_cycles", 32'(k), 32'd17);
    wait_tx(1);
    chk("tmo_nak", 32'(txq[tx_base]), 32'hEE);
    chk("tmo_err", 32'(err_cnt - err_base), 32'd1);
    chk("tmo_no_wr", 32'(wadr.size() - wr_base), 32'd0);
    chk("tmo_busy", 32'(BUSY), 32'd0);

    // TX back-pressure during a read response
    snap();
    rd_val = 32'hCAFEF00D;
    TX_READY = 1'b0;
    send_byte(8'h52); send_adr(24'h000020);
    k = 0;
    while (!TX_VALID && k < 50) begin @(posedge CLK); #1; k++; end
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("bp_valid", 32'(TX_VALID), 32'd1);
      chk("bp_data", 32'(TX_DATA), 32'hCA);
      chk("bp_rx_ready", 32'(RX_READY), 32'd0);
    end
    @(posedge CLK); #1;
    TX_READY = 1'b1;
    wait_tx(4);
    chk("bp_b0", 32'(txq[tx_base]),     32'hCA);
    chk("bp_b1", 32'(txq[tx_base + 1]), 32'hFE);
    chk("bp_b2", 32'(txq[tx_base + 2]), 32'hF0);
    chk("bp_b3", 32'(txq[tx_base + 3]), 32'h0D);

    // Reset in the middle of a burst
    snap();
    send_byte(8'h42); send_adr(24'h000040); send_byte(8'h00); send_byte(8'h03);
    send_word(32'hA1A2A3A4);
    send_byte(8'hB1); send_byte(8'hB2);
    idle(2);
    chk("mid_wr_count", 32'(wadr.size() - wr_base), 32'd1);
    chk("mid_busy", 32'(BUSY), 32'd1);
    RESET = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    idle(3);
    RESET = 1'b0;
    idle(20);
    chk("post_rst_wr", 32'(wadr.size() - wr_base), 32'd1);
    chk("post_rst_tx", 32'(txq.size() - tx_base), 32'd0);
    chk("post_rst_busy", 32'(BUSY), 32'd0);
    chk("post_rst_err", 32'(err_cnt - err_base), 32'd0);

    chk("strobe_collision", 32'(coll_cnt), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
